// File: rtl/vote_pkg.sv
// Shared definitions for the vote result reader: candidate count, default
// count width, candidate-ID encoding and the winner-scan FSM states.
package vote_pkg;

  localparam int NUM_CAND  = 4;
  localparam int CNT_W_DEF = 8;

  // Candidate IDs: 0 means "no candidate", 1..4 name a candidate.
  typedef logic [2:0] cand_id_t;

  localparam cand_id_t CAND_NONE = 3'd0;
  localparam cand_id_t CAND_1    = 3'd1;
  localparam cand_id_t CAND_2    = 3'd2;
  localparam cand_id_t CAND_3    = 3'd3;
  localparam cand_id_t CAND_4    = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SCAN    = 2'd1,
    ST_PRESENT = 2'd2
  } vote_state_e;

  // Map a zero-based candidate slot to its one-based candidate ID.
  function automatic cand_id_t idx_to_id(input logic [1:0] idx);
    return {1'b0, idx} + 3'd1;
  endfunction

endpackage

// File: rtl/vote_result_reader_if.sv
// Request/result handshake between a result consumer and the vote reader.
// master = consumer (issues requests, acknowledges), slave = the reader.
interface vote_result_reader_if #(
  parameter int CNT_W = 8
);
  import vote_pkg::*;

  logic             show_request;
  logic             result_ack;
  logic             busy;
  logic             result_valid;
  cand_id_t         winner_id;
  logic [CNT_W-1:0] winner_count;
  logic             tie;
  logic             no_votes;

  modport master (
    output show_request, result_ack,
    input  busy, result_valid, winner_id, winner_count, tie, no_votes
  );

  modport slave (
    input  show_request, result_ack,
    output busy, result_valid, winner_id, winner_count, tie, no_votes
  );

endinterface

// File: rtl/vote_max_step.sv
// One step of the running-maximum scan: folds a single candidate into the
// current leader. Strictly-greater wins, so the lowest index keeps a tie.
module vote_max_step
  import vote_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  cand_id_t         lead_id,
  input  logic [CNT_W-1:0] lead_count,
  input  logic             lead_tie,
  input  cand_id_t         cand_id,
  input  logic [CNT_W-1:0] cand_count,
  output cand_id_t         next_id,
  output logic [CNT_W-1:0] next_count,
  output logic             next_tie
);

  // Compare the candidate against the leader and produce the new leader.
  always_comb begin
    next_id    = lead_id;
    next_count = lead_count;
    next_tie   = lead_tie;
    if (cand_count > lead_count) begin
      next_id    = cand_id;
      next_count = cand_count;
      next_tie   = 1'b0;
    end else if ((cand_count == lead_count) && (lead_count != {CNT_W{1'b0}})) begin
      next_tie = 1'b1;
    end else begin
      next_tie = lead_tie;
    end
  end

endmodule

// File: rtl/vote_result_reader.sv
// Result-mode reader: on a show_request rising edge it snapshots the four
// vote totals, scans them one per cycle for the winner and presents the
// result until acknowledged. A separate display path shows the live total
// of a button-selected candidate, holding it for a while after release.
module vote_result_reader
  import vote_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int HOLD_CYCLES = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mode,
  input  logic [CNT_W-1:0] cand1_vote_recvd,
  input  logic [CNT_W-1:0] cand2_vote_recvd,
  input  logic [CNT_W-1:0] cand3_vote_recvd,
  input  logic [CNT_W-1:0] cand4_vote_recvd,
  input  logic             cand1_button,
  input  logic             cand2_button,
  input  logic             cand3_button,
  input  logic             cand4_button,
  output cand_id_t         display_id,
  output logic [CNT_W-1:0] display_count,
  vote_result_reader_if.slave bus
);

  localparam int HOLD_W = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(32'd1);
  localparam logic [2:0]        SCAN_DONE = 3'd4;

  vote_state_e      state_r, state_s;
  logic             start_s, load_s;
  logic             prev_req_r;
  logic [CNT_W-1:0] live_s [NUM_CAND];
  logic [CNT_W-1:0] snap_r [NUM_CAND];
  logic [2:0]       scan_idx_r;
  cand_id_t         lead_id_r, step_id_s;
  logic [CNT_W-1:0] lead_count_r, step_count_s;
  logic             lead_tie_r, step_tie_s;

  logic             busy_r, valid_r, tie_r, no_votes_r;
  cand_id_t         win_id_r;
  logic [CNT_W-1:0] win_count_r;

  cand_id_t         btn_sel_s, track_id_s, disp_id_r;
  logic [CNT_W-1:0] track_count_s, disp_count_r;
  logic [HOLD_W-1:0] hold_r;

  assign live_s[0] = cand1_vote_recvd;
  assign live_s[1] = cand2_vote_recvd;
  assign live_s[2] = cand3_vote_recvd;
  assign live_s[3] = cand4_vote_recvd;

  vote_max_step #(.CNT_W(CNT_W)) u_step (
    .lead_id    (lead_id_r),
    .lead_count (lead_count_r),
    .lead_tie   (lead_tie_r),
    .cand_id    (idx_to_id(scan_idx_r[1:0])),
    .cand_count (snap_r[scan_idx_r[1:0]]),
    .next_id    (step_id_s),
    .next_count (step_count_s),
    .next_tie   (step_tie_s)
  );

  // Next-state logic: mode low aborts any scan or presentation.
  always_comb begin
    state_s = state_r;
    start_s = 1'b0;
    load_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (mode && bus.show_request && !prev_req_r) begin
          state_s = ST_SCAN;
          start_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (!mode) begin
          state_s = ST_IDLE;
        end else if (scan_idx_r == SCAN_DONE) begin
          state_s = ST_PRESENT;
          load_s  = 1'b1;
        end else begin
          state_s = ST_SCAN;
        end
      end
      ST_PRESENT: begin
        if (!mode || bus.result_ack) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_PRESENT;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register, snapshot, running leader and registered result fields.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      prev_req_r   <= 1'b0;
      for (int i = 0; i < NUM_CAND; i++) snap_r[i] <= {CNT_W{1'b0}};
      scan_idx_r   <= 3'd0;
      lead_id_r    <= CAND_NONE;
      lead_count_r <= {CNT_W{1'b0}};
      lead_tie_r   <= 1'b0;
      busy_r       <= 1'b0;
      valid_r      <= 1'b0;
      win_id_r     <= CAND_NONE;
      win_count_r  <= {CNT_W{1'b0}};
      tie_r        <= 1'b0;
      no_votes_r   <= 1'b0;
    end else begin
      state_r    <= state_s;
      prev_req_r <= bus.show_request;
      if (start_s) begin
        for (int i = 0; i < NUM_CAND; i++) snap_r[i] <= live_s[i];
        scan_idx_r   <= 3'd0;
        lead_id_r    <= CAND_NONE;
        lead_count_r <= {CNT_W{1'b0}};
        lead_tie_r   <= 1'b0;
      end else if ((state_r == ST_SCAN) && (scan_idx_r != SCAN_DONE)) begin
        scan_idx_r   <= scan_idx_r + 3'd1;
        lead_id_r    <= step_id_s;
        lead_count_r <= step_count_s;
        lead_tie_r   <= step_tie_s;
      end
      busy_r  <= (state_s != ST_IDLE);
      valid_r <= (state_s == ST_PRESENT);
      if (load_s) begin
        win_id_r    <= lead_id_r;
        win_count_r <= lead_count_r;
        tie_r       <= lead_tie_r;
        no_votes_r  <= (lead_count_r == {CNT_W{1'b0}});
      end else if (state_s != ST_PRESENT) begin
        win_id_r    <= CAND_NONE;
        win_count_r <= {CNT_W{1'b0}};
        tie_r       <= 1'b0;
        no_votes_r  <= 1'b0;
      end
    end
  end

  // Highest-priority pressed button (candidate 1 first).
  always_comb begin
    btn_sel_s = CAND_NONE;
    if (cand1_button) begin
      btn_sel_s = CAND_1;
    end else if (cand2_button) begin
      btn_sel_s = CAND_2;
    end else if (cand3_button) begin
      btn_sel_s = CAND_3;
    end else if (cand4_button) begin
      btn_sel_s = CAND_4;
    end else begin
      btn_sel_s = CAND_NONE;
    end
  end

  // Live total of the candidate being shown (new press, else held selection).
  always_comb begin
    track_id_s    = (btn_sel_s != CAND_NONE) ? btn_sel_s : disp_id_r;
    track_count_s = {CNT_W{1'b0}};
    case (track_id_s)
      CAND_1:  track_count_s = live_s[0];
      CAND_2:  track_count_s = live_s[1];
      CAND_3:  track_count_s = live_s[2];
      CAND_4:  track_count_s = live_s[3];
      default: track_count_s = {CNT_W{1'b0}};
    endcase
  end

  // Display selection with post-release hold; independent of the scan FSM.
  always_ff @(posedge clock) begin
    if (reset || !mode) begin
      disp_id_r    <= CAND_NONE;
      disp_count_r <= {CNT_W{1'b0}};
      hold_r       <= {HOLD_W{1'b0}};
    end else if (btn_sel_s != CAND_NONE) begin
      disp_id_r    <= btn_sel_s;
      disp_count_r <= track_count_s;
      hold_r       <= HOLD_LOAD;
    end else if (hold_r != {HOLD_W{1'b0}}) begin
      disp_count_r <= track_count_s;
      hold_r       <= hold_r - HOLD_ONE;
    end else begin
      disp_id_r    <= CAND_NONE;
      disp_count_r <= {CNT_W{1'b0}};
    end
  end

  assign bus.busy         = busy_r;
  assign bus.result_valid = valid_r;
  assign bus.winner_id    = win_id_r;
  assign bus.winner_count = win_count_r;
  assign bus.tie          = tie_r;
  assign bus.no_votes     = no_votes_r;
  assign display_id       = disp_id_r;
  assign display_count    = disp_count_r;

endmodule
